// File: rtl/wbu.sv
// Write-back unit: latches one retired instruction from the LSU, commits GPR/CSR
// writes for one cycle, then hands the computed next PC to the IFU.
module wbu #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [63:0] MINSTRET_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in_lsu,
  output logic        ready_out_lsu,
  input  logic        ben,
  input  logic [31:0] pc,
  input  logic [6:0]  opcode,
  input  logic [31:0] alu_out,
  input  logic [31:0] csr_out,
  input  logic [31:0] rdata,
  input  logic        gpr_wen,
  input  logic [4:0]  rd,
  input  logic        csr_wen,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic [1:0]  rresp,
  input  logic [1:0]  bresp,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        gpr_we,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        csr_we0,
  output logic [11:0] csr_waddr0,
  output logic [31:0] csr_wdata0,
  output logic        csr_we1,
  output logic [11:0] csr_waddr1,
  output logic [31:0] csr_wdata1,
  output logic        valid_out_ifu,
  input  logic        ready_in_ifu,
  output logic [31:0] next_pc,
  output logic [63:0] minstret,
  output logic        bus_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_IFU, HALT} state_t;

  state_t      state_reg, state_next;
  logic        ben_reg, gpr_wen_reg, csr_wen_reg, is_ecall_reg, is_mret_reg;
  logic [31:0] pc_reg, alu_out_reg, csr_out_reg, rdata_reg, csr_wdata_reg;
  logic [31:0] mtvec_reg, mepc_reg;
  logic [6:0]  opcode_reg;
  logic [4:0]  rd_reg;
  logic [11:0] csr_waddr_reg;
  logic [31:0] next_pc_reg;
  logic [63:0] minstret_reg;

  logic        accept;
  logic        resp_err;
  logic        commit;
  logic [31:0] pc_plus4;
  logic [31:0] gpr_data;
  logic [31:0] pc_target;

  assign accept   = (state_reg == IDLE) && valid_in_lsu;
  // Bus errors are judged on the response presented with the handshake.
  assign resp_err = ((opcode == OP_LOAD) && (rresp != 2'b00)) ||
                    ((opcode == OP_STORE) && (bresp != 2'b00));
  assign commit   = (state_reg == COMMIT);
  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ben_reg       <= 1'b0;
      gpr_wen_reg   <= 1'b0;
      csr_wen_reg   <= 1'b0;
      is_ecall_reg  <= 1'b0;
      is_mret_reg   <= 1'b0;
      pc_reg        <= '0;
      alu_out_reg   <= '0;
      csr_out_reg   <= '0;
      rdata_reg     <= '0;
      csr_wdata_reg <= '0;
      mtvec_reg     <= '0;
      mepc_reg      <= '0;
      opcode_reg    <= '0;
      rd_reg        <= '0;
      csr_waddr_reg <= '0;
      next_pc_reg   <= RESET_PC;
      minstret_reg  <= MINSTRET_INIT;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ben_reg       <= ben;
        gpr_wen_reg   <= gpr_wen;
        csr_wen_reg   <= csr_wen;
        is_ecall_reg  <= is_ecall;
        is_mret_reg   <= is_mret;
        pc_reg        <= pc;
        alu_out_reg   <= alu_out;
        csr_out_reg   <= csr_out;
        rdata_reg     <= rdata;
        csr_wdata_reg <= csr_wdata;
        mtvec_reg     <= mtvec;
        mepc_reg      <= mepc;
        opcode_reg    <= opcode;
        rd_reg        <= rd;
        csr_waddr_reg <= csr_waddr;
      end
      if (commit) begin
        next_pc_reg  <= pc_target;
        minstret_reg <= minstret_reg + 64'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (valid_in_lsu) state_next = resp_err ? HALT : COMMIT;
      COMMIT:   state_next = WAIT_IFU;
      WAIT_IFU: if (ready_in_ifu) state_next = IDLE;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    gpr_data = alu_out_reg;
    case (opcode_reg)
      OP_LOAD:         gpr_data = rdata_reg;
      OP_JAL, OP_JALR: gpr_data = pc_plus4;
      OP_SYSTEM:       gpr_data = csr_out_reg;
      default:         gpr_data = alu_out_reg;
    endcase
  end

  always_comb begin
    pc_target = pc_plus4;
    if (is_ecall_reg)                 pc_target = mtvec_reg;
    else if (is_mret_reg)             pc_target = mepc_reg;
    else if (opcode_reg == OP_JAL)    pc_target = alu_out_reg;
    else if (opcode_reg == OP_JALR)   pc_target = alu_out_reg & ~32'd1;
    else if (opcode_reg == OP_BRANCH) pc_target = ben_reg ? alu_out_reg : pc_plus4;
  end

  // Write ports are quiet (zero) outside COMMIT so downstream sees clean pulses.
  always_comb begin
    gpr_we     = 1'b0;
    gpr_waddr  = '0;
    gpr_wdata  = '0;
    csr_we0    = 1'b0;
    csr_waddr0 = '0;
    csr_wdata0 = '0;
    csr_we1    = 1'b0;
    csr_waddr1 = '0;
    csr_wdata1 = '0;
    if (commit) begin
      gpr_we    = gpr_wen_reg && (rd_reg != 5'd0);
      gpr_waddr = rd_reg;
      gpr_wdata = gpr_data;
      if (is_ecall_reg) begin
        csr_we0    = 1'b1;
        csr_waddr0 = CSR_MEPC;
        csr_wdata0 = pc_reg;
        csr_we1    = 1'b1;
        csr_waddr1 = CSR_MCAUSE;
        csr_wdata1 = MCAUSE_ECALL;
      end else begin
        csr_we0    = csr_wen_reg;
        csr_waddr0 = csr_waddr_reg;
        csr_wdata0 = csr_wdata_reg;
      end
    end
  end

  assign ready_out_lsu = (state_reg == IDLE);
  assign valid_out_ifu = (state_reg == WAIT_IFU);
  assign bus_err       = (state_reg == HALT);
  assign next_pc       = next_pc_reg;
  assign minstret      = minstret_reg;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: each task drives one scenario and checks results inline.
module tb_wbu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in_lsu, valid2, ben, gpr_wen, csr_wen, is_ecall, is_mret, ready_in_ifu;
  logic [31:0] pc, alu_out, csr_out, rdata, csr_wdata, mtvec, mepc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [11:0] csr_waddr;
  logic [1:0]  rresp, bresp;

  logic        ready_out_lsu, gpr_we, csr_we0, csr_we1, valid_out_ifu, bus_err;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata, csr_wdata0, csr_wdata1, next_pc;
  logic [11:0] csr_waddr0, csr_waddr1;
  logic [63:0] minstret;

  logic        d2_ready, d2_gpr_we, d2_csr_we0, d2_csr_we1, d2_valid, d2_bus_err;
  logic [4:0]  d2_gpr_waddr;
  logic [31:0] d2_gpr_wdata, d2_csr_wdata0, d2_csr_wdata1, d2_next_pc;
  logic [11:0] d2_csr_waddr0, d2_csr_waddr1;
  logic [63:0] d2_minstret;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned exp_minstret = 0;

  always #5 clk = ~clk;

  wbu dut (
    .clk(clk), .rst(rst), .valid_in_lsu(valid_in_lsu), .ready_out_lsu(ready_out_lsu),
    .ben(ben), .pc(pc), .opcode(opcode), .alu_out(alu_out), .csr_out(csr_out), .rdata(rdata),
    .gpr_wen(gpr_wen), .rd(rd), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .is_ecall(is_ecall), .is_mret(is_mret), .rresp(rresp), .bresp(bresp), .mtvec(mtvec), .mepc(mepc),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_we0(csr_we0), .csr_waddr0(csr_waddr0), .csr_wdata0(csr_wdata0),
    .csr_we1(csr_we1), .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1),
    .valid_out_ifu(valid_out_ifu), .ready_in_ifu(ready_in_ifu), .next_pc(next_pc),
    .minstret(minstret), .bus_err(bus_err)
  );

  // Second instance starts its counter at the top to exercise the wrap.
  wbu #(.MINSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut2 (
    .clk(clk), .rst(rst), .valid_in_lsu(valid2), .ready_out_lsu(d2_ready),
    .ben(ben), .pc(pc), .opcode(opcode), .alu_out(alu_out), .csr_out(csr_out), .rdata(rdata),
    .gpr_wen(gpr_wen), .rd(rd), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .is_ecall(is_ecall), .is_mret(is_mret), .rresp(rresp), .bresp(bresp), .mtvec(mtvec), .mepc(mepc),
    .gpr_we(d2_gpr_we), .gpr_waddr(d2_gpr_waddr), .gpr_wdata(d2_gpr_wdata),
    .csr_we0(d2_csr_we0), .csr_waddr0(d2_csr_waddr0), .csr_wdata0(d2_csr_wdata0),
    .csr_we1(d2_csr_we1), .csr_waddr1(d2_csr_waddr1), .csr_wdata1(d2_csr_wdata1),
    .valid_out_ifu(d2_valid), .ready_in_ifu(ready_in_ifu), .next_pc(d2_next_pc),
    .minstret(d2_minstret), .bus_err(d2_bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_in_lsu = 0; valid2 = 0; ben = 0; gpr_wen = 0; csr_wen = 0; is_ecall = 0; is_mret = 0;
    pc = 0; alu_out = 0; csr_out = 0; rdata = 0; csr_wdata = 0; mtvec = 0; mepc = 0;
    opcode = 7'b0010011; rd = 0; csr_waddr = 0; rresp = 0; bresp = 0; ready_in_ifu = 0;
  endtask

  task automatic send();
    valid_in_lsu = 1;
    step();
    valid_in_lsu = 0;
  endtask

  task automatic accept();
    ready_in_ifu = 1;
    step();
    ready_in_ifu = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    step();
    exp_minstret = 0;
  endtask

  task automatic test_reset();
    clear_in();
    do_reset();
    n_cmp++; if (ready_out_lsu !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready_out_lsu); end
    n_cmp++; if (next_pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_next_pc got %h want 80000000", next_pc); end
    n_cmp++; if (minstret !== 64'd0) begin n_err++; $display("FAIL reset_minstret got %0d want 0", minstret); end
    n_cmp++; if ({bus_err, valid_out_ifu, gpr_we, csr_we0, csr_we1} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {bus_err, valid_out_ifu, gpr_we, csr_we0, csr_we1}); end
    n_cmp++; if ({gpr_waddr, gpr_wdata, csr_waddr0, csr_wdata0} !== '0) begin n_err++; $display("FAIL reset_wport nonzero addr/data"); end
    $display("reset: next_pc=%h minstret=%0d", next_pc, minstret);
  endtask

  task automatic test_addi();
    clear_in();
    pc = 32'h8000_0000; rd = 5; alu_out = 32'h1234; gpr_wen = 1;
    send();
    n_cmp++; if ({gpr_we, gpr_waddr, gpr_wdata} !== {1'b1, 5'd5, 32'h1234}) begin n_err++; $display("FAIL addi_gpr got we=%b a=%0d d=%h want 1/5/1234", gpr_we, gpr_waddr, gpr_wdata); end
    n_cmp++; if ({csr_we0, csr_we1, ready_out_lsu, valid_out_ifu} !== 4'b0) begin n_err++; $display("FAIL addi_commit_flags got %b want 0000", {csr_we0, csr_we1, ready_out_lsu, valid_out_ifu}); end
    step();
    exp_minstret++;
    n_cmp++; if ({gpr_we, valid_out_ifu} !== 2'b01) begin n_err++; $display("FAIL addi_wait got we=%b valid=%b want 0/1", gpr_we, valid_out_ifu); end
    n_cmp++; if (next_pc !== 32'h8000_0004) begin n_err++; $display("FAIL addi_next_pc got %h want 80000004", next_pc); end
    n_cmp++; if (minstret !== exp_minstret) begin n_err++; $display("FAIL addi_minstret got %0d want %0d", minstret, exp_minstret); end
    accept();
    n_cmp++; if ({valid_out_ifu, ready_out_lsu} !== 2'b01) begin n_err++; $display("FAIL addi_idle got valid=%b ready=%b want 0/1", valid_out_ifu, ready_out_lsu); end
    $display("addi: wdata=1234 next_pc=%h minstret=%0d", next_pc, minstret);
  endtask

  task automatic test_load_csr();
    clear_in();
    opcode = 7'b0000011; pc = 32'h8000_0004; rd = 0; gpr_wen = 1; rdata = 32'hDEAD_BEEF;
    send();
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL load_rd0_we got %b want 0", gpr_we); end
    n_cmp++; if (gpr_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_wdata got %h want deadbeef", gpr_wdata); end
    step();
    exp_minstret++;
    n_cmp++; if (next_pc !== 32'h8000_0008) begin n_err++; $display("FAIL load_next_pc got %h want 80000008", next_pc); end
    n_cmp++; if (minstret !== exp_minstret) begin n_err++; $display("FAIL load_minstret got %0d want %0d", minstret, exp_minstret); end
    accept();
    $display("load rd0: next_pc=%h", next_pc);
    clear_in();
    opcode = 7'b1110011; pc = 32'h8000_0008; rd = 7; gpr_wen = 1; csr_out = 32'hABCD;
    csr_wen = 1; csr_waddr = 12'h305; csr_wdata = 32'h8000_1000;
    send();
    n_cmp++; if ({gpr_we, gpr_waddr, gpr_wdata} !== {1'b1, 5'd7, 32'hABCD}) begin n_err++; $display("FAIL csr_gpr got we=%b a=%0d d=%h want 1/7/abcd", gpr_we, gpr_waddr, gpr_wdata); end
    n_cmp++; if ({csr_we0, csr_waddr0, csr_wdata0, csr_we1} !== {1'b1, 12'h305, 32'h8000_1000, 1'b0}) begin n_err++; $display("FAIL csr_port got we0=%b a=%h d=%h we1=%b want 1/305/80001000/0", csr_we0, csr_waddr0, csr_wdata0, csr_we1); end
    step();
    exp_minstret++;
    accept();
    $display("csrrw: gpr=abcd csr 305<=80001000");
  endtask

  task automatic test_jalr_branch();
    clear_in();
    opcode = 7'b1100111; pc = 32'h8000_0010; alu_out = 32'h8000_0101; rd = 1; gpr_wen = 1;
    send();
    n_cmp++; if (gpr_wdata !== 32'h8000_0014) begin n_err++; $display("FAIL jalr_link got %h want 80000014", gpr_wdata); end
    step();
    exp_minstret++;
    n_cmp++; if (next_pc !== 32'h8000_0100) begin n_err++; $display("FAIL jalr_next_pc got %h want 80000100", next_pc); end
    accept();
    $display("jalr: link=80000014 next_pc=%h", next_pc);
    for (int b = 0; b < 2; b++) begin
      clear_in();
      opcode = 7'b1100011; pc = 32'h8000_0040; alu_out = 32'h8000_0200; ben = (b == 1);
      send();
      n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL branch_we got %b want 0", gpr_we); end
      step();
      exp_minstret++;
      n_cmp++; if (next_pc !== ((b == 1) ? 32'h8000_0200 : 32'h8000_0044)) begin n_err++; $display("FAIL branch_ben%0d_next_pc got %h", b, next_pc); end
      accept();
      $display("branch ben=%0d: next_pc=%h", b, next_pc);
    end
  endtask

  task automatic test_ecall_mret();
    clear_in();
    opcode = 7'b1110011; is_ecall = 1; pc = 32'h8000_0020; mtvec = 32'h8000_1000;
    csr_wen = 1; csr_waddr = 12'h300; csr_wdata = 32'h5555;
    send();
    n_cmp++; if ({csr_we0, csr_waddr0, csr_wdata0} !== {1'b1, 12'h341, 32'h8000_0020}) begin n_err++; $display("FAIL ecall_port0 got we=%b a=%h d=%h want 1/341/80000020", csr_we0, csr_waddr0, csr_wdata0); end
    n_cmp++; if ({csr_we1, csr_waddr1, csr_wdata1} !== {1'b1, 12'h342, 32'd11}) begin n_err++; $display("FAIL ecall_port1 got we=%b a=%h d=%h want 1/342/b", csr_we1, csr_waddr1, csr_wdata1); end
    step();
    exp_minstret++;
    n_cmp++; if (next_pc !== 32'h8000_1000) begin n_err++; $display("FAIL ecall_next_pc got %h want 80001000", next_pc); end
    n_cmp++; if ({csr_we0, csr_we1} !== 2'b00) begin n_err++; $display("FAIL ecall_pulse_len got %b want 00", {csr_we0, csr_we1}); end
    accept();
    $display("ecall: mepc<=80000020 mcause<=11 next_pc=%h", next_pc);
    clear_in();
    opcode = 7'b1110011; is_mret = 1; pc = 32'h8000_1010; mepc = 32'h8000_0024;
    send();
    n_cmp++; if ({csr_we0, csr_we1} !== 2'b00) begin n_err++; $display("FAIL mret_csr_we got %b want 00", {csr_we0, csr_we1}); end
    step();
    exp_minstret++;
    n_cmp++; if (next_pc !== 32'h8000_0024) begin n_err++; $display("FAIL mret_next_pc got %h want 80000024", next_pc); end
    accept();
    $display("mret: next_pc=%h", next_pc);
  endtask

  task automatic test_hold();
    int pulses = 0;
    clear_in();
    pc = 32'h8000_0100; rd = 9; alu_out = 32'h55; gpr_wen = 1;
    send();
    if (gpr_we) pulses++;
    step();
    exp_minstret++;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({valid_out_ifu, ready_out_lsu} !== 2'b10) begin n_err++; $display("FAIL hold_flags cyc%0d got valid=%b ready=%b want 1/0", i, valid_out_ifu, ready_out_lsu); end
      n_cmp++; if (next_pc !== 32'h8000_0104) begin n_err++; $display("FAIL hold_next_pc cyc%0d got %h want 80000104", i, next_pc); end
      if (gpr_we) pulses++;
      step();
    end
    accept();
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    n_cmp++; if (valid_out_ifu !== 1'b0) begin n_err++; $display("FAIL hold_release got %b want 0", valid_out_ifu); end
    $display("hold: 5 stalled cycles, pulses=%0d", pulses);
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    int pulses = 0;
    clear_in();
    pc = 32'h8000_0200; rd = 2; alu_out = 32'h7; gpr_wen = 1;
    ready_in_ifu = 1; valid_in_lsu = 1;
    for (int i = 0; i < 9; i++) begin
      if (ready_out_lsu) hs++;
      if (gpr_we) pulses++;
      step();
    end
    valid_in_lsu = 0; ready_in_ifu = 0;
    exp_minstret += 3;
    n_cmp++; if (hs !== 3) begin n_err++; $display("FAIL b2b_handshakes got %0d want 3", hs); end
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    n_cmp++; if (minstret !== exp_minstret) begin n_err++; $display("FAIL b2b_minstret got %0d want %0d", minstret, exp_minstret); end
    n_cmp++; if ({ready_out_lsu, valid_out_ifu} !== 2'b10) begin n_err++; $display("FAIL b2b_end got ready=%b valid=%b want 1/0", ready_out_lsu, valid_out_ifu); end
    $display("back_to_back: %0d accepted in 9 cycles", hs);
  endtask

  task automatic test_halt();
    clear_in();
    opcode = 7'b0000011; pc = 32'h8000_0300; rd = 4; gpr_wen = 1; rdata = 32'hDEAD_BEEF; rresp = 2'd2;
    send();
    n_cmp++; if ({bus_err, ready_out_lsu, valid_out_ifu, gpr_we} !== 4'b1000) begin n_err++; $display("FAIL halt_entry got %b want 1000", {bus_err, ready_out_lsu, valid_out_ifu, gpr_we}); end
    valid_in_lsu = 1; ready_in_ifu = 1; rresp = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({bus_err, ready_out_lsu, valid_out_ifu, gpr_we, csr_we0} !== 5'b10000) begin n_err++; $display("FAIL halt_stuck cyc%0d got %b want 10000", i, {bus_err, ready_out_lsu, valid_out_ifu, gpr_we, csr_we0}); end
    end
    valid_in_lsu = 0; ready_in_ifu = 0;
    n_cmp++; if (minstret !== exp_minstret) begin n_err++; $display("FAIL halt_minstret got %0d want %0d", minstret, exp_minstret); end
    do_reset();
    n_cmp++; if ({bus_err, ready_out_lsu} !== 2'b01) begin n_err++; $display("FAIL halt_cleared got %b want 01", {bus_err, ready_out_lsu}); end
    $display("load rresp=2: halted, cleared by rst");
    clear_in();
    opcode = 7'b0100011; bresp = 2'd1;
    send();
    n_cmp++; if ({bus_err, csr_we0, gpr_we} !== 3'b100) begin n_err++; $display("FAIL store_halt got %b want 100", {bus_err, csr_we0, gpr_we}); end
    $display("store bresp=1: bus_err=%b", bus_err);
    do_reset();
  endtask

  task automatic test_rst_mid();
    clear_in();
    pc = 32'h8000_0400; rd = 3; alu_out = 32'h99; gpr_wen = 1;
    send();
    n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL rstmid_commit got %b want 1", gpr_we); end
    rst = 1;
    #1;
    n_cmp++; if ({gpr_we, valid_out_ifu, ready_out_lsu} !== 3'b001) begin n_err++; $display("FAIL rstmid_commit_out got %b want 001", {gpr_we, valid_out_ifu, ready_out_lsu}); end
    n_cmp++; if ({next_pc, minstret} !== {32'h8000_0000, 64'd0}) begin n_err++; $display("FAIL rstmid_regs got pc=%h m=%0d want 80000000/0", next_pc, minstret); end
    step(); rst = 0; step();
    send();
    step();
    n_cmp++; if (valid_out_ifu !== 1'b1) begin n_err++; $display("FAIL rstmid_wait got %b want 1", valid_out_ifu); end
    rst = 1;
    #1;
    n_cmp++; if ({valid_out_ifu, next_pc, minstret} !== {1'b0, 32'h8000_0000, 64'd0}) begin n_err++; $display("FAIL rstmid_wait_out got v=%b pc=%h m=%0d want 0/80000000/0", valid_out_ifu, next_pc, minstret); end
    step(); rst = 0; step();
    exp_minstret = 0;
    $display("rst mid-flight: instruction dropped");
  endtask

  task automatic test_wrap();
    clear_in();
    do_reset();
    n_cmp++; if (d2_minstret !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffffffffffffffff", d2_minstret); end
    pc = 32'h8000_0500; rd = 6; alu_out = 32'h1; gpr_wen = 1;
    valid2 = 1;
    step();
    valid2 = 0;
    step();
    n_cmp++; if (d2_minstret !== 64'd0) begin n_err++; $display("FAIL wrap_minstret got %h want 0", d2_minstret); end
    n_cmp++; if ({d2_valid, d2_next_pc} !== {1'b1, 32'h8000_0504}) begin n_err++; $display("FAIL wrap_next_pc got v=%b pc=%h want 1/80000504", d2_valid, d2_next_pc); end
    accept();
    $display("wrap: minstret=%0d", d2_minstret);
  endtask

  initial begin
    clear_in();
    test_reset();
    test_addi();
    test_load_csr();
    test_jalr_branch();
    test_ecall_mret();
    test_hold();
    test_back_to_back();
    test_halt();
    test_rst_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
